// File: rtl/axi4_lite_regfile_slave.sv
`default_nettype none
// ============================================================================
// Module   : axi4_lite_regfile_slave
// Purpose  : AXI4-Lite responder that maps a bank of 32-bit registers.
//            AW and W are accepted independently, in either order; the write
//            commits once both halves are present. Byte strobes are honoured.
//            Register 0 is a read-only ID word; register 1 is also exported
//            on ctrl_q. Out-of-range or read-only writes, and out-of-range
//            reads, return SLVERR.
// Ports    : clk, rst             - clock, synchronous active-high reset
//            aw*/w*/b*            - AXI4-Lite write address/data/response
//            ar*/r*               - AXI4-Lite read address/data
//            ctrl_q               - current contents of register 1
// Revision : 1.0 - initial release
// ============================================================================
module axi4_lite_regfile_slave #(
  parameter int          ADDR_W   = 32,
  parameter int          NUM_REGS = 8,
  parameter logic [31:0] ID_VALUE = 32'hA11C_0001
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic              awvalid,
  output logic              awready,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic              wvalid,
  output logic              wready,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  input  logic [ADDR_W-1:0] araddr,
  input  logic              arvalid,
  output logic              arready,
  output logic [31:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rvalid,
  input  logic              rready,
  output logic [31:0]       ctrl_q
);

  localparam logic [1:0] c_resp_okay   = 2'b00;
  localparam logic [1:0] c_resp_slverr = 2'b10;

  // Register index compare is done at 64 bits so that any ADDR_W up to 66
  // and any NUM_REGS compare without truncation.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
    return 64'(a[ADDR_W-1:2]) < 64'(NUM_REGS);
  endfunction

  function automatic logic addr_is_idx(input logic [ADDR_W-1:0] a, input int i);
    return 64'(a[ADDR_W-1:2]) == 64'(i);
  endfunction

  // Register 0 is a constant, so only 1..NUM_REGS-1 are storage.
  logic [31:0]       regs_q [1:NUM_REGS-1];
  logic [31:0]       regs_d [1:NUM_REGS-1];

  logic              aw_held_q, aw_held_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic              w_held_q, w_held_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              rvalid_q, rvalid_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;

  logic              aw_hs, w_hs, ar_hs, commit;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [3:0]        wr_strb;
  logic [31:0]       rd_val;
  logic              unused_addr_lsbs;

  assign awready = !rst && !aw_held_q && !bvalid_q;
  assign wready  = !rst && !w_held_q && !bvalid_q;
  assign arready = !rst && !rvalid_q;

  assign bvalid = bvalid_q;
  assign bresp  = bresp_q;
  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;
  assign rresp  = rresp_q;
  assign ctrl_q = regs_q[1];

  // Byte offset within a word carries no meaning for this register bank.
  assign unused_addr_lsbs = ^{wr_addr[1:0], araddr[1:0]};

  always_comb begin
    aw_hs = awvalid && awready;
    w_hs  = wvalid && wready;
    ar_hs = arvalid && arready;

    // A half arriving on the commit edge is used directly, not via its latch.
    wr_addr = aw_hs ? awaddr : awaddr_q;
    wr_data = w_hs  ? wdata  : wdata_q;
    wr_strb = w_hs  ? wstrb  : wstrb_q;
    commit  = (aw_held_q || aw_hs) && (w_held_q || w_hs);

    regs_d    = regs_q;
    aw_held_d = aw_held_q;
    awaddr_d  = awaddr_q;
    w_held_d  = w_held_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;

    // ---------------- write path ----------------
    if (aw_hs) begin
      aw_held_d = 1'b1;
      awaddr_d  = awaddr;
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = wdata;
      wstrb_d  = wstrb;
    end
    if (bvalid_q && bready) begin
      bvalid_d = 1'b0;
    end
    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = (addr_in_range(wr_addr) && !addr_is_idx(wr_addr, 0))
                  ? c_resp_okay : c_resp_slverr;
      for (int i = 1; i < NUM_REGS; i++) begin
        if (addr_is_idx(wr_addr, i)) begin
          for (int b = 0; b < 4; b++) begin
            if (wr_strb[b]) begin
              regs_d[i][8*b +: 8] = wr_data[8*b +: 8];
            end
          end
        end
      end
    end

    // ---------------- read path ----------------
    // Reads sample regs_q, so a same-edge write commit is not yet visible.
    rd_val = '0;
    if (addr_is_idx(araddr, 0)) begin
      rd_val = ID_VALUE;
    end
    for (int i = 1; i < NUM_REGS; i++) begin
      if (addr_is_idx(araddr, i)) begin
        rd_val = regs_q[i];
      end
    end

    if (rvalid_q && rready) begin
      rvalid_d = 1'b0;
    end
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_val;
      rresp_d  = addr_in_range(araddr) ? c_resp_okay : c_resp_slverr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      aw_held_q <= 1'b0;
      awaddr_q  <= '0;
      w_held_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= c_resp_okay;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= c_resp_okay;
    end else begin
      regs_q    <= regs_d;
      aw_held_q <= aw_held_d;
      awaddr_q  <= awaddr_d;
      w_held_q  <= w_held_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

endmodule
`default_nettype wire

// File: doc/axi4_lite_regfile_slave.md
Name: axi4_lite_regfile_slave

Overview:
AXI4-Lite responder that terminates a master's write and read transactions into a bank of memory-mapped 32-bit registers. AW and W channels are accepted independently and in either order. Byte strobes are honoured. Out-of-range and read-only accesses return SLVERR. It sits behind the team's AXI4-Lite master as a standalone peripheral register block, with register 1 exported as a control word.

Parameters:
ADDR_W, 32, AXI address width.
NUM_REGS, 8, number of 32-bit registers (index 0 to NUM_REGS-1); must be at least 2.
ID_VALUE, 32'hA11C_0001, constant returned by read-only register 0.

Ports:
clk  in  1  clock; all logic on the rising edge.
rst  in  1  synchronous, active-high reset.
awaddr  in  ADDR_W  write address.
awvalid  in  1  write address valid.
awready  out  1  write address ready.
wdata  in  32  write data.
wstrb  in  4  byte enables; bit i qualifies wdata[8i+7:8i].
wvalid  in  1  write data valid.
wready  out  1  write data ready.
bresp  out  2  write response: 2'b00 OKAY, 2'b10 SLVERR.
bvalid  out  1  write response valid.
bready  in  1  write response ready.
araddr  in  ADDR_W  read address.
arvalid  in  1  read address valid.
arready  out  1  read address ready.
rdata  out  32  read data.
rresp  out  2  read response.
rvalid  out  1  read data valid.
rready  in  1  read data ready.
ctrl_q  out  32  current contents of register 1.

Behaviour:
- Reset (rst high at a clock edge):
  - Register 0 reads ID_VALUE; registers 1 to NUM_REGS-1 are cleared to 0.
  - bvalid, rvalid, bresp, rresp, rdata and ctrl_q are 0.
  - Internal aw_held and w_held flags clear.
  - awready, wready and arready are forced to 0 while rst is high.
  - Reset mid-transaction drops the transaction: no register update and no response.
- Address decode:
  - idx = addr[ADDR_W-1:2]; addr[1:0] is ignored.
  - idx >= NUM_REGS is out-of-range.
- Write path:
  - awready = !rst & !aw_held & !bvalid.
  - wready = !rst & !w_held & !bvalid.
  - An AW handshake latches awaddr and sets aw_held. A W handshake latches wdata/wstrb and sets w_held.
  - Commit edge: the edge at which both halves are held, counting halves accepted on that same edge and using the incoming values.
  - At the commit edge the write is performed, bvalid is set and both held flags clear.
  - Latency: AW and W both handshaking in cycle 0 gives bvalid=1 and the updated register visible in cycle 1.
  - Write rule: only bytes with wstrb=1 are updated; wstrb=4'b0000 updates nothing and returns OKAY.
  - idx=0 or out-of-range: no update, bresp=SLVERR. Otherwise bresp=OKAY.
  - bvalid and bresp stay stable until the bvalid & bready edge, which clears bvalid.
  - A new AW or W is accepted from the cycle after that.
- Read path:
  - arready = !rst & !rvalid.
  - An AR handshake loads rdata/rresp and sets rvalid at the same edge, so rvalid is high in the following cycle (1-cycle latency).
  - idx=0 returns ID_VALUE with OKAY. In-range returns the register value with OKAY. Out-of-range returns rdata=0 with SLVERR.
  - rdata, rresp and rvalid are held stable until the rvalid & rready edge.
  - Back-to-back reads: the next AR is accepted in the cycle after that edge.
- Read and write channels are independent.
  - When an AR handshake and a write commit to the same register occur on the same edge, the read returns the pre-write value.
- ctrl_q is register 1 after the edge; it updates in the same cycle that bvalid rises.

Test Plan:
- Reset, then read idx 0 (araddr=0x0) -> rvalid 1 cycle after AR, rdata=0xA11C0001, rresp=OKAY; all readies 0 during reset.
- AW(0x4) and W(0xDEADBEEF, wstrb=4'hF) in the same cycle -> bvalid next cycle with OKAY, ctrl_q=0xDEADBEEF; read 0x4 returns 0xDEADBEEF.
- W(0x11223344, 4'hF) two cycles before AW(0x8) -> wready low after W accepted, bvalid the cycle after AW handshake; then W(0xAABBCCDD, wstrb=4'b0101) to 0x8 -> read 0x8 returns 0x11BB33DD.
- Write to 0x0 and to 0x20 (idx 8) -> bresp=SLVERR, register 0 still ID_VALUE; read 0x20 -> rdata=0, rresp=SLVERR.
- Hold bready=0 for 5 cycles -> bvalid/bresp stable, awready=wready=0 throughout; hold rready=0 -> rdata stable, arready=0.
- Reg 2=0x5; AR(0x8) on the same edge as a commit of 0x9 to 0x8 -> rdata=0x5, a subsequent read returns 0x9. Separately, assert rst while AW is held without W -> no update, bvalid stays 0.
